// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared pipeline clear codes and hazard controller states
package riscv_pipe_pkg;

  localparam logic [1:0] CLR_PASS  = 2'b00;
  localparam logic [1:0] CLR_HOLD  = 2'b01;
  localparam logic [1:0] CLR_FLUSH = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MD_BUSY  = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_stall_timer.sv
// rtl/hazard_ctrl_stall_timer.sv - loadable down-counter with zero flag for mul/div occupancy
module stall_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load has priority over decrement; the count never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, cleared immediately by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - five-stage pipeline hazard controller (load-use, branch, mul/div, mem wait)
module hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int MD_CYCLES = 8,
  parameter int CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_md_start,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic [1:0]  clr_ifid,
  output logic [1:0]  clr_idex,
  output logic [1:0]  clr_exmem,
  output logic [1:0]  clr_memwb,
  output logic        pc_hold,
  output logic        busy,
  output logic [15:0] stall_cycles
);

  // The entry cycle in RUN is the first of MD_CYCLES, and the zero-count
  // cycle in MD_BUSY is the last, so the timer starts at MD_CYCLES-2.
  localparam bit               MD_STALLS = (MD_CYCLES > 1);
  localparam logic [CNT_W-1:0] MD_LOAD   = MD_STALLS ? CNT_W'(MD_CYCLES - 2) : '0;

  hazard_state_t state_q, state_d;
  hazard_state_t saved_q, saved_d;
  hazard_state_t eff_state;
  logic          md_load, md_dec, md_zero;
  logic          mem_stall, load_use;
  logic [15:0]   stall_q, stall_d;

  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

  stall_timer #(
    .CNT_W(CNT_W)
  ) u_md_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (md_load),
    .load_val_i(MD_LOAD),
    .en_i      (md_dec),
    .zero_o    (md_zero)
  );

  // Prioritised hazard resolution; leaving MEM_WAIT evaluates from the restored state.
  always_comb begin
    clr_ifid  = CLR_PASS;
    clr_idex  = CLR_PASS;
    clr_exmem = CLR_PASS;
    clr_memwb = CLR_PASS;
    pc_hold   = 1'b0;
    md_load   = 1'b0;
    md_dec    = 1'b0;
    eff_state = (state_q == ST_MEM_WAIT) ? saved_q : state_q;
    state_d   = ST_RUN;
    saved_d   = saved_q;
    if (rst) begin
      clr_ifid  = CLR_FLUSH;
      clr_idex  = CLR_FLUSH;
      clr_exmem = CLR_FLUSH;
      clr_memwb = CLR_FLUSH;
      pc_hold   = 1'b1;
      saved_d   = ST_RUN;
    end else if (mem_stall) begin
      clr_ifid  = CLR_HOLD;
      clr_idex  = CLR_HOLD;
      clr_exmem = CLR_HOLD;
      clr_memwb = CLR_FLUSH;
      pc_hold   = 1'b1;
      state_d   = ST_MEM_WAIT;
      saved_d   = eff_state;
    end else if (eff_state == ST_MD_BUSY) begin
      if (!md_zero) begin
        clr_ifid  = CLR_HOLD;
        clr_idex  = CLR_HOLD;
        clr_exmem = CLR_FLUSH;
        pc_hold   = 1'b1;
        md_dec    = 1'b1;
        state_d   = ST_MD_BUSY;
      end
    end else if (ex_md_start && MD_STALLS) begin
      clr_ifid  = CLR_HOLD;
      clr_idex  = CLR_HOLD;
      clr_exmem = CLR_FLUSH;
      pc_hold   = 1'b1;
      md_load   = 1'b1;
      state_d   = ST_MD_BUSY;
    end else if (ex_branch_taken) begin
      clr_ifid  = CLR_FLUSH;
      clr_idex  = CLR_FLUSH;
    end else if (load_use) begin
      clr_ifid  = CLR_HOLD;
      clr_idex  = CLR_FLUSH;
      pc_hold   = 1'b1;
    end
  end

  // Saturating count of PC-hold cycles.
  always_comb begin
    stall_d = stall_q;
    if (pc_hold && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // State, saved state and performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      saved_q <= ST_RUN;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      stall_q <= stall_d;
    end
  end

  assign busy         = ~rst && (state_q != ST_RUN);
  assign stall_cycles = stall_q;

endmodule
